// File: rtl/encoder_8b10b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8b10b_pkg
// Description : Shared types and constants for the 8B/10B encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_8b10b_pkg;

    // Running-disparity encoding shared with the decoder
    typedef enum logic [1:0] {
        RD_NULL = 2'b00,
        RD_POS  = 2'b01,
        RD_NEG  = 2'b10
    } rd_t;

    // 6b/4b codes are held in abcdei / fghj order, 'a' and 'f' in the MSB
    localparam logic [4:0] c_k28_x         = 5'd28;
    localparam logic [5:0] c_k28_6b_rdneg  = 6'b001111;
    localparam logic [5:0] c_k28_6b_rdpos  = 6'b110000;
    localparam logic [3:0] c_a7_rdneg      = 4'b0111;
    localparam logic [3:0] c_a7_rdpos      = 4'b1000;

    typedef struct packed {
        logic [5:0] code6;
        logic       unbal6;
        logic       cmp6;
        logic [3:0] fghj_neg;
        logic [3:0] fghj_pos;
        logic       kerr;
    } s1_t;

    function automatic logic is_a7_rdneg(input logic [4:0] x);
        return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
    endfunction

    function automatic logic is_a7_rdpos(input logic [4:0] x);
        return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
    endfunction

    function automatic logic is_k_a7_x(input logic [4:0] x);
        return (x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30);
    endfunction

    // Map transmission-order codes onto dout, where bit 0 carries 'a' / 'f'
    function automatic logic [5:0] rev6(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_8b10b_5b6b.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8b10b_5b6b
// Description : 5b/6b data lookup returning the RD- code and its balance.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8b10b_5b6b (
    input  logic [4:0] i_x,
    output logic [5:0] o_code6_rdneg,
    output logic       o_unbal
);

    always_comb begin
        o_code6_rdneg = 6'b000000;
        case (i_x)
            5'd0:  o_code6_rdneg = 6'b100111;
            5'd1:  o_code6_rdneg = 6'b011101;
            5'd2:  o_code6_rdneg = 6'b101101;
            5'd3:  o_code6_rdneg = 6'b110001;
            5'd4:  o_code6_rdneg = 6'b110101;
            5'd5:  o_code6_rdneg = 6'b101001;
            5'd6:  o_code6_rdneg = 6'b011001;
            5'd7:  o_code6_rdneg = 6'b111000;
            5'd8:  o_code6_rdneg = 6'b111001;
            5'd9:  o_code6_rdneg = 6'b100101;
            5'd10: o_code6_rdneg = 6'b010101;
            5'd11: o_code6_rdneg = 6'b110100;
            5'd12: o_code6_rdneg = 6'b001101;
            5'd13: o_code6_rdneg = 6'b101100;
            5'd14: o_code6_rdneg = 6'b011100;
            5'd15: o_code6_rdneg = 6'b010111;
            5'd16: o_code6_rdneg = 6'b011011;
            5'd17: o_code6_rdneg = 6'b100011;
            5'd18: o_code6_rdneg = 6'b010011;
            5'd19: o_code6_rdneg = 6'b110010;
            5'd20: o_code6_rdneg = 6'b001011;
            5'd21: o_code6_rdneg = 6'b101010;
            5'd22: o_code6_rdneg = 6'b011010;
            5'd23: o_code6_rdneg = 6'b111010;
            5'd24: o_code6_rdneg = 6'b110011;
            5'd25: o_code6_rdneg = 6'b100110;
            5'd26: o_code6_rdneg = 6'b010110;
            5'd27: o_code6_rdneg = 6'b110110;
            5'd28: o_code6_rdneg = 6'b001110;
            5'd29: o_code6_rdneg = 6'b101110;
            5'd30: o_code6_rdneg = 6'b011110;
            default: o_code6_rdneg = 6'b101011;
        endcase
    end

    // D.7 (111000) counts as balanced here; its RD+ inversion is handled by the caller
    assign o_unbal = ($countones(o_code6_rdneg) != 3);

endmodule
`default_nettype wire

// File: rtl/encoder_8b10b.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8b10b
// Description : Two-stage 8B/10B encoder with running-disparity tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8b10b #(
    parameter bit INIT_RD_NEG = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       kin,
    input  logic       din_valid,
    output logic [9:0] dout,
    output logic       dout_valid,
    output logic       kerr,
    output logic       rd_pos
);
    import encoder_8b10b_pkg::*;

    localparam rd_t c_rd_init = INIT_RD_NEG ? RD_NEG : RD_POS;

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [5:0] w_d6;
    logic       w_d6_unbal;
    logic       w_k28;
    logic       w_k_a7;
    s1_t        w_s1;

    logic       r_s1_valid;
    s1_t        r_s1;
    logic [9:0] r_dout;
    logic       r_dout_valid;
    logic       r_kerr;
    rd_t        r_rd;

    assign w_x = din[4:0];
    assign w_y = din[7:5];

    encoder_8b10b_5b6b u_5b6b (
        .i_x           (w_x),
        .o_code6_rdneg (w_d6),
        .o_unbal       (w_d6_unbal)
    );

    assign w_k28  = kin && (w_x == c_k28_x);
    assign w_k_a7 = kin && (w_y == 3'd7) && is_k_a7_x(w_x);

    // Stage 1: both polarities of each sub-block; fghj_neg/pos are keyed on RD at the 4b point
    always_comb begin
        w_s1        = '0;
        w_s1.code6  = w_d6;
        w_s1.unbal6 = w_d6_unbal;
        w_s1.cmp6   = w_d6_unbal || (w_x == 5'd7);
        case (w_y)
            3'd0: begin w_s1.fghj_neg = 4'b1011; w_s1.fghj_pos = 4'b0100; end
            3'd1: begin w_s1.fghj_neg = 4'b1001; w_s1.fghj_pos = 4'b1001; end
            3'd2: begin w_s1.fghj_neg = 4'b0101; w_s1.fghj_pos = 4'b0101; end
            3'd3: begin w_s1.fghj_neg = 4'b1100; w_s1.fghj_pos = 4'b0011; end
            3'd4: begin w_s1.fghj_neg = 4'b1101; w_s1.fghj_pos = 4'b0010; end
            3'd5: begin w_s1.fghj_neg = 4'b1010; w_s1.fghj_pos = 4'b1010; end
            3'd6: begin w_s1.fghj_neg = 4'b0110; w_s1.fghj_pos = 4'b0110; end
            default: begin
                w_s1.fghj_neg = is_a7_rdneg(w_x) ? c_a7_rdneg : 4'b1110;
                w_s1.fghj_pos = is_a7_rdpos(w_x) ? c_a7_rdpos : 4'b0001;
            end
        endcase
        if (w_k28) begin
            w_s1.code6  = c_k28_6b_rdneg;
            w_s1.unbal6 = 1'b1;
            w_s1.cmp6   = 1'b1;
            case (w_y)
                3'd0:    w_s1.fghj_pos = 4'b0100;
                3'd1:    w_s1.fghj_pos = 4'b1001;
                3'd2:    w_s1.fghj_pos = 4'b0101;
                3'd3:    w_s1.fghj_pos = 4'b0011;
                3'd4:    w_s1.fghj_pos = 4'b0010;
                3'd5:    w_s1.fghj_pos = 4'b1010;
                3'd6:    w_s1.fghj_pos = 4'b0110;
                default: w_s1.fghj_pos = 4'b1000;
            endcase
            w_s1.fghj_neg = ~w_s1.fghj_pos;
        end else if (w_k_a7) begin
            w_s1.fghj_neg = c_a7_rdneg;
            w_s1.fghj_pos = c_a7_rdpos;
        end
        w_s1.kerr = kin && !w_k28 && !w_k_a7;
    end

    logic       w_rd_neg;
    logic       w_mid_neg;
    logic       w_out_neg;
    logic [5:0] w_c6;
    logic [3:0] w_c4;

    // Stage 2: polarity selection against the running disparity
    assign w_rd_neg  = (r_rd == RD_NEG);
    assign w_c6      = (!w_rd_neg && r_s1.cmp6) ? ~r_s1.code6 : r_s1.code6;
    assign w_mid_neg = r_s1.unbal6 ? !w_rd_neg : w_rd_neg;
    assign w_c4      = w_mid_neg ? r_s1.fghj_neg : r_s1.fghj_pos;
    assign w_out_neg = ($countones(w_c4) != 2) ? !w_mid_neg : w_mid_neg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_kerr       <= 1'b0;
            r_rd         <= c_rd_init;
        end else begin
            r_s1_valid   <= din_valid;
            if (din_valid) begin
                r_s1 <= w_s1;
            end
            r_dout_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dout <= {rev4(w_c4), rev6(w_c6)};
                r_kerr <= r_s1.kerr;
                r_rd   <= w_out_neg ? RD_NEG : RD_POS;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign kerr       = r_kerr;
    assign rd_pos     = (r_rd == RD_POS);

endmodule
`default_nettype wire
